// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the program loader.
//   state_t         - loader FSM states
//   DEPTH_DEFAULT   - default instruction-memory depth in words
//   DATA_W_DEFAULT  - default instruction word width
//   NOP_WORD        - word written into unused memory after a short program
package prog_loader_pkg;

  localparam int DEPTH_DEFAULT  = 16;
  localparam int DATA_W_DEFAULT = 8;

  localparam logic [7:0] NOP_WORD = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: program word stream in, instruction-memory write port out.
//   in_valid / in_data / in_last / in_ready : upstream word handshake
//   mem_we / mem_addr / mem_wdata           : instruction-memory write strobe, address, data
// Modports:
//   master - the side that supplies words and observes the memory port
//   slave  - the loader
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory while holding the CPU
// in reset, pads the remainder of memory with NOPs, then releases the CPU.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-high
//   start        - one-cycle request to begin a load (ignored while loading)
//   bus          - prog_loader_if.slave: word stream in, memory write port out
//   cpu_hold     - CPU held in reset while high (low only when load is done)
//   load_done    - program loaded and CPU released
//   load_error   - DEPTH words accepted without in_last
//   words_loaded - upstream words accepted in the current load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEFAULT,
  parameter  int DATA_W = DATA_W_DEFAULT,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW     = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            load_error,
  output logic [CW-1:0]   words_loaded
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Write address advance, wrapping at DEPTH even when DEPTH is not a power of two.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    if (a == LAST_ADDR) return '0;
    return a + AW'(1);
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [CW-1:0]     words_q;

  logic              hs;
  logic              wr;
  logic              clr;
  logic [DATA_W-1:0] wr_data;

  logic              we_p1;
  logic [AW-1:0]     addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    clr     = 1'b0;
    wr_data = '0;
    hs      = bus.in_valid && (state_q == S_LOAD);
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          clr     = 1'b1;
        end
      end
      S_LOAD: begin
        if (hs) begin
          wr      = 1'b1;
          wr_data = bus.in_data;
          if (addr_q == LAST_ADDR)
            state_d = bus.in_last ? S_DONE : S_ERROR;
          else if (bus.in_last)
            state_d = S_FILL;
        end
      end
      S_FILL: begin
        // Stay in FILL until the last NOP write is actually on the memory
        // port, so load_done rises only on the cycle after that write.
        if (we_p1 && (addr_p1 == LAST_ADDR)) begin
          state_d = S_DONE;
        end else begin
          wr      = 1'b1;
          wr_data = DATA_W'(NOP_WORD);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p0 -> p1: register the memory write, advance counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      words_q  <= '0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      we_p1 <= wr;
      if (wr) begin
        addr_p1  <= addr_q;
        wdata_p1 <= wr_data;
        addr_q   <= addr_inc(addr_q);
      end
      if (hs) words_q <= words_q + CW'(1);
      if (clr) begin
        addr_q  <= '0;
        words_q <= '0;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.mem_we    = we_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;

  assign cpu_hold      = (state_q != S_DONE);
  assign load_done     = (state_q == S_DONE);
  assign load_error    = (state_q == S_ERROR);
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader (DEPTH=16, DATA_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cpu_hold, load_done, load_error;
  logic [4:0] words_loaded;

  int n_chk  = 0;
  int n_fail = 0;

  prog_loader_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  prog_loader #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int a, input int d);
    chk({tag, "_we"},   32'(bus.mem_we),    32'd1);
    chk({tag, "_addr"}, 32'(bus.mem_addr),  32'(a));
    chk({tag, "_data"}, 32'(bus.mem_wdata), 32'(d));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
    chk({tag, "_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),      32'd1);
    chk({tag, "_done"},  32'(load_done),     32'd0);
    chk({tag, "_err"},   32'(load_error),    32'd0);
    chk({tag, "_words"}, 32'(words_loaded),  32'd0);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1w [3];
    t1w = '{8'hA0, 8'hB0, 8'hC0};
    drive(1'b0, 8'h00, 1'b0);

    // Reset values while held and right after release.
    repeat (2) @(negedge clk);
    chk_rst("rst_held");
    reset = 1'b0;
    @(negedge clk);
    chk_rst("rst_idle");

    // Short program: 3 words then NOP fill of 3..15.
    pulse_start();
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    chk("t1_words0", 32'(words_loaded), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, t1w[i], i == 2);
      @(negedge clk);
      chk_wr("t1_w", i, t1w[i]);
      chk("t1_words", 32'(words_loaded), 32'(i + 1));
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("t1_ready_after_last", 32'(bus.in_ready), 32'd0);
    for (int a = 3; a < 16; a++) begin
      @(negedge clk);
      chk_wr("t1_fill", a, 0);
      chk("t1_fill_words", 32'(words_loaded), 32'd3);
      chk("t1_fill_done", 32'(load_done), 32'd0);
      chk("t1_fill_hold", 32'(cpu_hold), 32'd1);
    end
    @(negedge clk);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_we_idle", 32'(bus.mem_we), 32'd0);
    chk("t1_err", 32'(load_error), 32'd0);

    // Full program: 16 words, last on the 16th, no fill.
    pulse_start();
    chk("t2_done_clr", 32'(load_done), 32'd0);
    chk("t2_words_clr", 32'(words_loaded), 32'd0);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h10 + i), i == 15);
      @(negedge clk);
      chk_wr("t2_w", i, 8'h10 + i);
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("t2_words", 32'(words_loaded), 32'd16);
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t2_no_fill", 32'(bus.mem_we), 32'd0);
    chk("t2_done_hold", 32'(load_done), 32'd1);

    // Overflow: 16 words, in_last never set.
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h20 + i), 1'b0);
      @(negedge clk);
      chk_wr("t3_w", i, 8'h20 + i);
      if (i < 15) chk("t3_err_early", 32'(load_error), 32'd0);
    end
    chk("t3_err", 32'(load_error), 32'd1);
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    chk("t3_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_words", 32'(words_loaded), 32'd16);
    chk("t3_done", 32'(load_done), 32'd0);
    drive(1'b1, 8'hEE, 1'b0);
    @(negedge clk);
    chk("t3_no_write", 32'(bus.mem_we), 32'd0);
    drive(1'b0, 8'h00, 1'b0);

    // Toggled in_valid: 4 words, one write per handshake, gaps hold state.
    pulse_start();
    chk("t4_err_clr", 32'(load_error), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0);
      @(negedge clk);
      chk_wr("t4_w", i, 8'h30 + i);
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("t4_gap_we", 32'(bus.mem_we), 32'd0);
      chk("t4_gap_words", 32'(words_loaded), 32'(i + 1));
    end

    // Reset after the 2nd handshake, then reload from address 0.
    reset = 1'b1;
    #1;
    chk_rst("t5_rst_pre");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    drive(1'b1, 8'h40, 1'b0);
    @(negedge clk);
    chk_wr("t5_w0", 0, 8'h40);
    drive(1'b1, 8'h41, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk_rst("t5_rst_mid_load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_we", 32'(bus.mem_we), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    drive(1'b1, 8'h50, 1'b1);
    @(negedge clk);
    chk_wr("t5_reload", 0, 8'h50);
    chk("t5_reload_words", 32'(words_loaded), 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_wr("t5_fill1", 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_rst("t5_rst_mid_fill");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // start pulsed during LOAD is ignored.
    pulse_start();
    drive(1'b1, 8'h60, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h61, 1'b0);
    @(negedge clk);
    chk_wr("t6_w1", 1, 8'h61);
    drive(1'b0, 8'h00, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_words", 32'(words_loaded), 32'd2);
    chk("t6_no_we", 32'(bus.mem_we), 32'd0);
    drive(1'b1, 8'h62, 1'b0);
    @(negedge clk);
    chk_wr("t6_w2", 2, 8'h62);
    chk("t6_words3", 32'(words_loaded), 32'd3);
    drive(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
